// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared widths, reset PC and pointer sizing for the fetch unit
package ifu_pkg;
    localparam int XLEN = 32;
    localparam int INST_BYTES = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One extra bit beyond the slot index so full and empty are distinguishable
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/ifu_if.sv
// rtl/ifu_if.sv - redirect, instruction-memory and decode-side signals of the fetch unit
interface ifu_if;
    import ifu_pkg::*;

    logic            take;
    logic [XLEN-1:0] dest;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        input  take, dest, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output take, dest, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/ifu_buf.sv
// rtl/ifu_buf.sv - instruction slot ring: PC captured at grant, word at response, popped in order
module ifu_buf
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = ptr_w(DEPTH),
    localparam int IW = PW - 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic            fill_wr_i,
    input  logic [XLEN-1:0] fill_data_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic [PW-1:0]   occ_o,
    output logic [PW-1:0]   pend_o,
    output logic            valid_o,
    output logic [XLEN-1:0] head_inst_o,
    output logic [XLEN-1:0] head_pc_o
);
    logic [PW-1:0]   alloc_q, fill_q, rd_q;
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] inst_q [DEPTH];

    assign occ_o       = alloc_q - rd_q;
    assign pend_o      = alloc_q - fill_q;
    assign valid_o     = (fill_q != rd_q);
    assign head_inst_o = inst_q[rd_q[IW-1:0]];
    assign head_pc_o   = pc_q[rd_q[IW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_q <= '0;
            fill_q  <= '0;
            rd_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (flush_i) begin
            // rd is kept: a pop in the flush cycle is squashed by decode
            alloc_q <= rd_q;
            fill_q  <= rd_q;
        end else begin
            if (alloc_i) begin
                pc_q[alloc_q[IW-1:0]] <= alloc_pc_i;
                alloc_q <= alloc_q + 1'b1;
            end
            if (fill_i) begin
                if (fill_wr_i) begin
                    inst_q[fill_q[IW-1:0]] <= fill_data_i;
                end
                fill_q <= fill_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - fetch unit top: PC, fetch credit, wrong-path drop counter; IFU_BYPASS_EN adds a response bypass
module ifu
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    ifu_if.master bus
);
    localparam int PW = ptr_w(BUF_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(BUF_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   occ, pend;
    logic [PW:0]     credit_used;
    logic            grant, keep, pop, bypass_hit, buf_valid, fill_wr;
    logic [XLEN-1:0] head_inst, head_pc;

    // Slots already owned plus responses still to be discarded bound new requests
    assign credit_used   = {1'b0, occ} + {1'b0, drop_q};
    assign bus.imem_req  = !rst && !bus.take && (credit_used < DEPTH_C);
    assign bus.imem_addr = pc_q;

    assign grant = bus.imem_req & bus.imem_gnt;
    assign keep  = bus.imem_rvalid & (drop_q == '0) & !bus.take;

`ifdef IFU_BYPASS_EN
    assign bypass_hit = keep & !buf_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    // On a bypass the head slot is the one being filled, so its stored PC is correct
    assign bus.inst_valid = buf_valid | bypass_hit;
    assign bus.inst       = bypass_hit ? bus.imem_rdata : head_inst;
    assign bus.inst_pc    = head_pc;

    assign pop     = bus.inst_valid & bus.inst_ready & !bus.take;
    assign fill_wr = !(bypass_hit & pop);

    ifu_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .alloc_i     (grant),
        .alloc_pc_i  (pc_q),
        .fill_i      (keep),
        .fill_wr_i   (fill_wr),
        .fill_data_i (bus.imem_rdata),
        .pop_i       (pop),
        .flush_i     (bus.take),
        .occ_o       (occ),
        .pend_o      (pend),
        .valid_o     (buf_valid),
        .head_inst_o (head_inst),
        .head_pc_o   (head_pc)
    );

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (bus.take) begin
            pc_d = bus.dest;
            // Everything still in flight becomes wrong-path; a word arriving now is consumed here
            drop_d = drop_q + pend - {{(PW-1){1'b0}}, bus.imem_rvalid};
        end else begin
            if (grant) begin
                pc_d = pc_q + XLEN'(INST_BYTES);
            end
            if (bus.imem_rvalid && drop_q != '0) begin
                drop_d = drop_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end
endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - directed bench for ifu with an in-order latency-configurable memory model
module tb_ifu;
`ifdef IFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk;
    logic rst;
    ifu_if bus();

    int n_tests = 0;
    int n_fail  = 0;
    int mem_lat = 1;
    int cyc     = 0;

    mreq_t       mq[$];
    logic [31:0] grant_q[$];
    logic [31:0] pop_q[$];
    logic [31:0] data_q[$];

    ifu #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: returns ~addr, in order, mem_lat cycles after the grant cycle
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (rst) begin
                mq.delete();
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = '0;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = ~mq[0].addr;
                mq.delete(0);
            end else begin
                bus.imem_rvalid = 1'b0;
            end
            @(negedge clk);
            if (!rst && bus.imem_req && bus.imem_gnt) begin
                mq.push_back('{bus.imem_addr, cyc + mem_lat});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.imem_req && bus.imem_gnt) grant_q.push_back(bus.imem_addr);
                if (bus.inst_valid && bus.inst_ready && !bus.take) begin
                    pop_q.push_back(bus.inst_pc);
                    data_q.push_back(bus.inst);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic do_reset(input int lat, input logic rdy);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.take = 1'b0;
        bus.inst_ready = rdy;
        mem_lat = lat;
        @(posedge clk); #1;
        grant_q.delete();
        pop_q.delete();
        data_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.take = 1'b0;
        bus.dest = '0;
        bus.imem_gnt = 1'b1;
        bus.inst_ready = 1'b1;
        mem_lat = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        n_tests++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid); end
        n_tests++; if (bus.inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", bus.inst); end
        n_tests++; if (bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 0", bus.inst_pc); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
        n_tests++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h want 0", bus.imem_addr); end
        n_tests++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid: got %b want 0", bus.inst_valid); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (bus.inst_valid !== BYP) begin n_fail++; $display("FAIL resp_latency_valid: got %b want %b", bus.inst_valid, BYP); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL second_cycle_valid: got %b want 1", bus.inst_valid); end
        n_tests++; if (bus.inst_pc !== (BYP ? 32'h4 : 32'h0)) begin n_fail++; $display("FAIL second_cycle_pc: got %h want %h", bus.inst_pc, BYP ? 32'h4 : 32'h0); end
    endtask

    task automatic test_stream();
        repeat (12) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= grant_q.size() || grant_q[i] !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stream_addr[%0d]: got %h want %h", i, (i < grant_q.size()) ? grant_q[i] : 32'hx, 32'(4 * i));
            end
            n_tests++;
            if (i >= pop_q.size() || pop_q[i] !== 32'(4 * i) || data_q[i] !== ~32'(4 * i)) begin
                n_fail++;
                $display("FAIL stream_pop[%0d]: got pc %h inst %h want pc %h inst %h", i,
                         (i < pop_q.size()) ? pop_q[i] : 32'hx, (i < data_q.size()) ? data_q[i] : 32'hx,
                         32'(4 * i), ~32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b want 0", bus.imem_req); end
        n_tests++; if (bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_pc_hold: got %h want 8", bus.imem_addr); end
        n_tests++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b want 1", bus.inst_valid); end
        n_tests++; if (bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL stall_inst_pc: got %h want 0", bus.inst_pc); end
        n_tests++; if (grant_q.size() !== 2) begin n_fail++; $display("FAIL stall_grants: got %0d want 2", grant_q.size()); end
        @(posedge clk); #1;
        bus.inst_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_tests++; if (grant_q.size() < 3 || grant_q[2] !== 32'h8) begin n_fail++; $display("FAIL stall_resume_addr: got %h want 8", (grant_q.size() > 2) ? grant_q[2] : 32'hx); end
        n_tests++; if (pop_q.size() < 2 || pop_q[0] !== 32'h0 || pop_q[1] !== 32'h4) begin n_fail++; $display("FAIL stall_resume_pops: got %0d pops want 0 then 4", pop_q.size()); end
    endtask

    task automatic test_redirect();
        do_reset(3, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.take = 1'b1;
        bus.dest = 32'h100;
        @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_take_req: got %b want 0", bus.imem_req); end
        @(posedge clk); #1;
        bus.take = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_drop_credit: got %b want 0", bus.imem_req); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got req %b addr %h want 1 100", bus.imem_req, bus.imem_addr); end
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_tests++; if (grant_q.size() < 3 || grant_q[2] !== 32'h100) begin n_fail++; $display("FAIL redir_grant_seq: got %h want 100", (grant_q.size() > 2) ? grant_q[2] : 32'hx); end
        n_tests++; if (pop_q.size() < 1 || pop_q[0] !== 32'h100 || data_q[0] !== ~32'h100) begin n_fail++; $display("FAIL redir_first_pop: got pc %h inst %h want 100 %h", (pop_q.size() > 0) ? pop_q[0] : 32'hx, (data_q.size() > 0) ? data_q[0] : 32'hx, ~32'h100); end
    endtask

    task automatic test_take_rvalid();
        do_reset(1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.take = 1'b1;
        bus.dest = 32'h200;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL coinc_take_req: got %b want 0", bus.imem_req); end
        @(posedge clk); #1;
        bus.take = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL coinc_next_addr: got req %b addr %h want 1 200", bus.imem_req, bus.imem_addr); end
        n_tests++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL coinc_flushed: got %b want 0", bus.inst_valid); end
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_tests++; if (pop_q.size() < 2 || pop_q[0] !== 32'h200 || pop_q[1] !== 32'h204) begin n_fail++; $display("FAIL coinc_pops: got %h %h want 200 204", (pop_q.size() > 0) ? pop_q[0] : 32'hx, (pop_q.size() > 1) ? pop_q[1] : 32'hx); end
    endtask

    task automatic test_pc_wrap();
        do_reset(1, 1'b1);
        bus.take = 1'b1;
        bus.dest = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        bus.take = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_dest_addr: got req %b addr %h want 1 fffffffc", bus.imem_req, bus.imem_addr); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: got req %b addr %h want 1 0", bus.imem_req, bus.imem_addr); end
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_tests++; if (pop_q.size() < 2 || pop_q[0] !== 32'hFFFF_FFFC || pop_q[1] !== 32'h0 || data_q[0] !== 32'h3) begin n_fail++; $display("FAIL wrap_pops: got %h %h want fffffffc 0", (pop_q.size() > 0) ? pop_q[0] : 32'hx, (pop_q.size() > 1) ? pop_q[1] : 32'hx); end
    endtask

    task automatic test_mid_reset();
        do_reset(1, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.inst_valid !== 1'b1 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_full: got valid %b req %b want 1 0", bus.inst_valid, bus.imem_req); end
        @(posedge clk); #1;
        rst = 1'b1;
        #3;
        n_tests++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got req %b valid %b want 0 0", bus.imem_req, bus.inst_valid); end
        n_tests++; if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_data: got inst %h pc %h addr %h want 0 0 0", bus.inst, bus.inst_pc, bus.imem_addr); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_release: got req %b addr %h want 1 0", bus.imem_req, bus.imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_take_rvalid();
        test_pc_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
